// File: rtl/sequential_divider_pkg.sv
// Shared types and width helpers for the restoring sequential divider.
// Imported by the controller, the datapath and the top.
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sd_state_t;

    localparam int SD_DIVIDEND_W = 8;
    localparam int SD_DIVISOR_W  = 4;

    // Iteration counter width; never collapses to zero bits.
    function automatic int sd_cnt_w(input int dividend_w);
        return (dividend_w > 1) ? $clog2(dividend_w) : 1;
    endfunction

endpackage

// File: rtl/sequential_divider_if.sv
// Request/result bundle of the sequential divider.
// The requester is the master, the divider is the slave.
interface sequential_divider_if #(
    parameter int DIVIDEND_W = sd_pkg::SD_DIVIDEND_W,
    parameter int DIVISOR_W  = sd_pkg::SD_DIVISOR_W
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/sequential_divider_control.sv
// Sequencing for the restoring divider: state, iteration counter, busy/done.
//   state | meaning
//   IDLE  | waiting for start, results held
//   RUN   | one quotient bit per cycle, counter counts down to 0
//   DONE  | one-cycle done strobe, a new start is accepted here too
module sequential_divider_control
    import sd_pkg::*;
#(
    parameter int DIVIDEND_W = SD_DIVIDEND_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic divisor_zero,
    output logic load,
    output logic zero_load,
    output logic step,
    output logic busy,
    output logic done
);
    localparam int CNT_W = sd_cnt_w(DIVIDEND_W);

    sd_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // Datapath strobes act on the same edge as the state change they belong to.
    assign accept    = start && (state != RUN);
    assign load      = accept && !divisor_zero;
    assign zero_load = accept && divisor_zero;
    assign step      = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    if (accept && divisor_zero) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (accept) begin
                        state <= RUN;
                        cnt   <= CNT_W'(DIVIDEND_W - 1);
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/sequential_divider_datapath.sv
// Divisor/quotient/remainder registers and the restoring compare-subtract.
// The quotient register doubles as the dividend shift register.
module sequential_divider_datapath
    import sd_pkg::*;
#(
    parameter int DIVIDEND_W = SD_DIVIDEND_W,
    parameter int DIVISOR_W  = SD_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  zero_load,
    input  logic                  step,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  divisor_zero,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    logic [DIVISOR_W-1:0] div_q;
    logic [DIVISOR_W:0]   partial;
    logic                 ge;
    logic [DIVISOR_W-1:0] rem_next;

    assign divisor_zero = (divisor == '0);

    assign partial  = {remainder, quotient[DIVIDEND_W-1]};
    assign ge       = (partial >= {1'b0, div_q});
    // The difference is below the divisor, so the low bits hold it exactly.
    assign rem_next = ge ? (partial[DIVISOR_W-1:0] - div_q) : partial[DIVISOR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (zero_load) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
        end else if (load) begin
            div_q       <= divisor;
            quotient    <= dividend;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (step) begin
            quotient    <= {quotient[DIVIDEND_W-2:0], ge};
            remainder   <= rem_next;
        end
    end
endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// quotient/remainder returned with a one-cycle done strobe.
module sequential_divider
    import sd_pkg::*;
#(
    parameter int DIVIDEND_W = SD_DIVIDEND_W,
    parameter int DIVISOR_W  = SD_DIVISOR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    sequential_divider_if.slave     bus
);
    logic load;
    logic zero_load;
    logic step;
    logic divisor_zero;

    sequential_divider_control #(
        .DIVIDEND_W (DIVIDEND_W)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .start        (bus.start),
        .divisor_zero (divisor_zero),
        .load         (load),
        .zero_load    (zero_load),
        .step         (step),
        .busy         (bus.busy),
        .done         (bus.done)
    );

    sequential_divider_datapath #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_dp (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .zero_load    (zero_load),
        .step         (step),
        .dividend     (bus.dividend),
        .divisor      (bus.divisor),
        .divisor_zero (divisor_zero),
        .quotient     (bus.quotient),
        .remainder    (bus.remainder),
        .div_by_zero  (bus.div_by_zero)
    );
endmodule
